// File: rtl/core_mdu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | core_mdu_pkg : RV32M opcode fields and MDU state encodings            |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
package core_mdu_pkg;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] FUNCT3_MUL    = 3'b000;
  localparam logic [2:0] FUNCT3_MULH   = 3'b001;
  localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
  localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
  localparam logic [2:0] FUNCT3_DIV    = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
  localparam logic [2:0] FUNCT3_REM    = 3'b110;
  localparam logic [2:0] FUNCT3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_MUL  = 2'd1,
    MDU_DIV  = 2'd2,
    MDU_DONE = 2'd3
  } mdu_state_e;

  function automatic logic a_is_signed(input logic [2:0] f3);
    return (f3 == FUNCT3_MULH) || (f3 == FUNCT3_MULHSU) ||
           (f3 == FUNCT3_DIV)  || (f3 == FUNCT3_REM);
  endfunction

  function automatic logic b_is_signed(input logic [2:0] f3);
    return (f3 == FUNCT3_MULH) || (f3 == FUNCT3_DIV) || (f3 == FUNCT3_REM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/core_mdu_divstep.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | core_mdu_divstep : one radix-2 restoring divide iteration             |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
module core_mdu_divstep
  import core_mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quo_out
);

  logic [XLEN:0] w_shifted;
  logic [XLEN:0] w_diff;
  logic          w_fits;

  assign w_shifted = {rem_in, quo_in[XLEN-1]};
  assign w_diff    = w_shifted - {1'b0, divisor};
  // rem_in < divisor keeps the difference inside (-2^XLEN, 2^XLEN), so the MSB is its sign
  assign w_fits    = ~w_diff[XLEN];

  assign rem_out = w_fits ? w_diff[XLEN-1:0] : w_shifted[XLEN-1:0];
  assign quo_out = {quo_in[XLEN-2:0], w_fits};

endmodule
`default_nettype wire

// File: rtl/core_mdu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | core_mdu : iterative RV32M multiply/divide unit with valid/ready      |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
module core_mdu
  import core_mdu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MUL_STEP = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_idx,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [4:0]      out_rd_idx,
  output logic            busy
);

  localparam int              CW             = $clog2(XLEN) + 1;
  localparam logic [CW-1:0]   c_mul_cnt_init = CW'(XLEN / MUL_STEP - 1);
  localparam logic [CW-1:0]   c_div_cnt_init = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] c_int_min      = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e          r_state, w_next_state;
  logic [1:0]          r_op_sel;
  logic [4:0]          r_rd_idx;
  logic                r_sign_a, r_sign_b;
  logic [XLEN-1:0]     r_mag_a, r_mag_b;
  logic [2*XLEN-1:0]   r_prod;
  logic [CW-1:0]       r_cnt;
  logic [XLEN-1:0]     r_result;
  logic [4:0]          r_out_rd_idx;

  logic                w_accept, w_sign_a, w_sign_b;
  logic                w_div_zero, w_div_ovf, w_fast;
  logic [XLEN-1:0]     w_mag_a, w_mag_b, w_fast_result;

  assign in_ready   = (r_state == MDU_IDLE) & ~flush;
  assign busy       = (r_state != MDU_IDLE);
  assign out_valid  = (r_state == MDU_DONE);
  assign result     = r_result;
  assign out_rd_idx = r_out_rd_idx;

  assign w_accept   = in_valid & in_ready;
  assign w_sign_a   = a_is_signed(funct3) & op_a[XLEN-1];
  assign w_sign_b   = b_is_signed(funct3) & op_b[XLEN-1];
  assign w_mag_a    = w_sign_a ? -op_a : op_a;
  assign w_mag_b    = w_sign_b ? -op_b : op_b;

  // RISC-V defines these divide results without iterating
  assign w_div_zero    = (op_b == '0);
  assign w_div_ovf     = ~funct3[0] & (op_a == c_int_min) & (op_b == {XLEN{1'b1}});
  assign w_fast        = funct3[2] & (w_div_zero | w_div_ovf);
  assign w_fast_result = w_div_zero ? (funct3[1] ? op_a : {XLEN{1'b1}})
                                    : (funct3[1] ? {XLEN{1'b0}} : op_a);

  // Shift-add: low half of r_prod holds unconsumed multiplier bits
  logic [XLEN+MUL_STEP-1:0] w_partial, w_mul_sum;
  logic [2*XLEN-1:0]        w_mul_next, w_mul_signed;
  logic [XLEN-1:0]          w_mul_result;

  assign w_partial    = {{MUL_STEP{1'b0}}, r_mag_a} * {{XLEN{1'b0}}, r_prod[MUL_STEP-1:0]};
  assign w_mul_sum    = {{MUL_STEP{1'b0}}, r_prod[2*XLEN-1:XLEN]} + w_partial;
  assign w_mul_next   = {w_mul_sum, r_prod[XLEN-1:MUL_STEP]};
  assign w_mul_signed = (r_sign_a ^ r_sign_b) ? -w_mul_next : w_mul_next;
  assign w_mul_result = (r_op_sel == 2'b00) ? w_mul_signed[XLEN-1:0]
                                            : w_mul_signed[2*XLEN-1:XLEN];

  // Divide: r_prod = {partial remainder, dividend/quotient}
  logic [XLEN-1:0] w_rem_next, w_quo_next, w_quo_fix, w_rem_fix, w_div_result;

  core_mdu_divstep #(.XLEN(XLEN)) u_divstep (
    .rem_in  (r_prod[2*XLEN-1:XLEN]),
    .quo_in  (r_prod[XLEN-1:0]),
    .divisor (r_mag_b),
    .rem_out (w_rem_next),
    .quo_out (w_quo_next)
  );

  assign w_quo_fix    = (r_sign_a ^ r_sign_b) ? -w_quo_next : w_quo_next;
  assign w_rem_fix    = r_sign_a ? -w_rem_next : w_rem_next;
  assign w_div_result = r_op_sel[1] ? w_rem_fix : w_quo_fix;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= MDU_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      MDU_IDLE: if (w_accept) w_next_state = w_fast ? MDU_DONE : (funct3[2] ? MDU_DIV : MDU_MUL);
      MDU_MUL,
      MDU_DIV:  if (r_cnt == '0) w_next_state = MDU_DONE;
      MDU_DONE: if (out_ready) w_next_state = MDU_IDLE;
      default:  w_next_state = MDU_IDLE;
    endcase
    if (flush) w_next_state = MDU_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_sel     <= '0;
      r_rd_idx     <= '0;
      r_sign_a     <= 1'b0;
      r_sign_b     <= 1'b0;
      r_mag_a      <= '0;
      r_mag_b      <= '0;
      r_prod       <= '0;
      r_cnt        <= '0;
      r_result     <= '0;
      r_out_rd_idx <= '0;
    end else if (!flush) begin
      case (r_state)
        MDU_IDLE: begin
          if (w_accept) begin
            r_op_sel <= funct3[1:0];
            r_rd_idx <= rd_idx;
            r_sign_a <= w_sign_a;
            r_sign_b <= w_sign_b;
            r_mag_a  <= w_mag_a;
            r_mag_b  <= w_mag_b;
            r_prod   <= {{XLEN{1'b0}}, funct3[2] ? w_mag_a : w_mag_b};
            r_cnt    <= funct3[2] ? c_div_cnt_init : c_mul_cnt_init;
            if (w_fast) begin
              r_result     <= w_fast_result;
              r_out_rd_idx <= rd_idx;
            end
          end
        end
        MDU_MUL: begin
          r_prod <= w_mul_next;
          r_cnt  <= r_cnt - CW'(1);
          if (r_cnt == '0) begin
            r_result     <= w_mul_result;
            r_out_rd_idx <= r_rd_idx;
          end
        end
        MDU_DIV: begin
          r_prod <= {w_rem_next, w_quo_next};
          r_cnt  <= r_cnt - CW'(1);
          if (r_cnt == '0) begin
            r_result     <= w_div_result;
            r_out_rd_idx <= r_rd_idx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_core_mdu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_core_mdu : randomized self-checking bench for core_mdu             |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_core_mdu;

  localparam logic [2:0] F_MUL = 3'd0, F_MULH = 3'd1, F_MULHSU = 3'd2, F_MULHU = 3'd3;
  localparam logic [2:0] F_DIV = 3'd4, F_DIVU = 3'd5, F_REM = 3'd6, F_REMU = 3'd7;

  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic        in_valid = 1'b0, in_valid4 = 1'b0, out_ready = 1'b0, out_ready4 = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] op_a = '0, op_b = '0;
  logic [4:0]  rd_idx = '0;
  logic        in_ready, out_valid, busy, in_ready4, out_valid4, busy4;
  logic [31:0] result, result4;
  logic [4:0]  out_rd_idx, out_rd_idx4;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  core_mdu #(.XLEN(32), .MUL_STEP(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .funct3(funct3), .op_a(op_a), .op_b(op_b), .rd_idx(rd_idx), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .out_rd_idx(out_rd_idx), .busy(busy)
  );

  core_mdu #(.XLEN(32), .MUL_STEP(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid4), .in_ready(in_ready4),
    .funct3(funct3), .op_a(op_a), .op_b(op_b), .rd_idx(rd_idx), .out_valid(out_valid4),
    .out_ready(out_ready4), .result(result4), .out_rd_idx(out_rd_idx4), .busy(busy4)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Architectural RV32M results from 64-bit integer arithmetic
  function automatic logic [31:0] ref_mdu(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] ua, ub, p;
    logic [31:0] res;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'h0, a};
    ub  = {32'h0, b};
    res = '0;
    case (f)
      F_MUL:    begin p = ua * ub;                 res = p[31:0];  end
      F_MULH:   begin p = 64'(sa * sb);            res = p[63:32]; end
      F_MULHSU: begin p = 64'(sa * longint'(ub));  res = p[63:32]; end
      F_MULHU:  begin p = ua * ub;                 res = p[63:32]; end
      F_DIV:    if (b == 0) res = 32'hFFFF_FFFF; else res = 32'(sa / sb);
      F_DIVU:   if (b == 0) res = 32'hFFFF_FFFF; else res = a / b;
      F_REM:    if (b == 0) res = a;             else res = 32'(sa % sb);
      default:  if (b == 0) res = a;             else res = a % b;
    endcase
    return res;
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input int step);
    if (!f[2]) return 32 / step + 1;
    if (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic release_out(input bit sel);
    @(negedge clk);
    if (sel) out_ready4 = 1'b1; else out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("in_ready_after_hs", sel ? in_ready4 : in_ready, 1);
    check_eq("valid_drop_after_hs", sel ? out_valid4 : out_valid, 0);
    out_ready  = 1'b0;
    out_ready4 = 1'b0;
  endtask

  // Issue one request and wait for its result; latency counts the accept edge as 1
  task automatic do_op(input bit sel, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] idx, input logic [31:0] exp_res, input int exp_lat,
                       input bit rel, input string tag);
    int lat;
    @(negedge clk);
    funct3 = f; op_a = a; op_b = b; rd_idx = idx;
    if (sel) in_valid4 = 1'b1; else in_valid = 1'b1;
    check_eq({tag, "/in_ready"}, sel ? in_ready4 : in_ready, 1);
    @(posedge clk); #1;
    lat = 1;
    in_valid = 1'b0; in_valid4 = 1'b0;
    funct3 = 3'($urandom); op_a = $urandom; op_b = $urandom; rd_idx = 5'($urandom);
    while (!(sel ? out_valid4 : out_valid) && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq({tag, "/latency"}, 64'(lat), 64'(exp_lat));
    check_eq({tag, "/result"}, sel ? result4 : result, exp_res);
    check_eq({tag, "/rd_idx"}, sel ? out_rd_idx4 : out_rd_idx, idx);
    if (rel) release_out(sel);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  f;
    logic [31:0] a, b;
    int          seen;

    #2;
    check_eq("rst/in_ready", in_ready, 1);
    check_eq("rst/busy", busy, 0);
    check_eq("rst/out_valid", out_valid, 0);
    check_eq("rst/result", result, 0);
    check_eq("rst/out_rd_idx", out_rd_idx, 0);
    @(negedge clk); rst_n = 1'b1;

    do_op(0, F_MUL, 32'd7, 32'hFFFF_FFFD, 5'd3, 32'hFFFF_FFEB, 33, 1, "mul_s1");
    do_op(1, F_MUL, 32'd7, 32'hFFFF_FFFD, 5'd4, 32'hFFFF_FFEB, 9, 1, "mul_s4");

    do_op(0, F_MULH,   32'h8000_0000, 32'h8000_0000, 5'd5, 32'h4000_0000, 33, 1, "mulh");
    do_op(0, F_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFE, 33, 1, "mulhu");
    do_op(0, F_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFF, 33, 1, "mulhsu");

    do_op(0, F_DIV,  32'hFFFF_FFF9, 32'd2, 5'd8,  32'hFFFF_FFFD, 33, 1, "div_neg");
    do_op(0, F_REM,  32'hFFFF_FFF9, 32'd2, 5'd9,  32'hFFFF_FFFF, 33, 1, "rem_neg");
    do_op(0, F_DIVU, 32'd100, 32'd7, 5'd10, 32'd14, 33, 1, "divu");
    do_op(0, F_REMU, 32'd100, 32'd7, 5'd11, 32'd2,  33, 1, "remu");

    do_op(0, F_DIV,  32'd5, 32'd0, 5'd12, 32'hFFFF_FFFF, 1, 1, "div_by0");
    do_op(0, F_REMU, 32'd5, 32'd0, 5'd13, 32'd5, 1, 1, "remu_by0");
    do_op(0, F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 1, 1, "div_ovf");
    do_op(0, F_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'd0, 1, 1, "rem_ovf");
    do_op(0, F_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0, 33, 1, "divu_noovf");

    // Backpressure, then a request presented during the handshake cycle
    do_op(0, F_MUL, 32'd12345, 32'd678, 5'd17, 32'd8369910, 33, 0, "bp");
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check_eq("bp/out_valid", out_valid, 1);
      check_eq("bp/result", result, 32'd8369910);
      check_eq("bp/in_ready", in_ready, 0);
      check_eq("bp/busy", busy, 1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1; funct3 = F_DIVU; op_a = 32'd1000; op_b = 32'd10; rd_idx = 5'd18;
    @(posedge clk); #1;
    check_eq("bp/in_ready_next", in_ready, 1);
    check_eq("bp/no_accept_in_hs", busy, 0);
    out_ready = 1'b0; in_valid = 1'b0;
    do_op(0, F_DIVU, 32'd1000, 32'd10, 5'd18, 32'd100, 33, 1, "b2b");

    // Flush mid-divide
    @(negedge clk);
    in_valid = 1'b1; funct3 = F_DIV; op_a = 32'd1000; op_b = 32'd3; rd_idx = 5'd19;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1;
    check_eq("flush/busy", busy, 0);
    check_eq("flush/out_valid", out_valid, 0);
    check_eq("flush/in_ready_held", in_ready, 0);
    @(negedge clk); flush = 1'b0; #1;
    check_eq("flush/in_ready", in_ready, 1);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check_eq("flush/no_valid", 64'(seen), 0);
    do_op(0, F_MUL, 32'd6, 32'd7, 5'd20, 32'd42, 33, 1, "after_flush");

    // Asynchronous reset mid-multiply
    @(negedge clk);
    in_valid = 1'b1; funct3 = F_MULHU; op_a = 32'hDEAD_BEEF; op_b = 32'h1234_5678; rd_idx = 5'd21;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check_eq("arst/busy_before", busy, 1);
    rst_n = 1'b0; #1;
    check_eq("arst/busy", busy, 0);
    check_eq("arst/out_valid", out_valid, 0);
    check_eq("arst/in_ready", in_ready, 1);
    check_eq("arst/result", result, 0);
    check_eq("arst/out_rd_idx", out_rd_idx, 0);
    @(negedge clk); rst_n = 1'b1;

    // Flush wins over the output handshake
    do_op(0, F_DIV, 32'd50, 32'd5, 5'd22, 32'd10, 33, 0, "flush_done");
    @(negedge clk); flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("flush_done/out_valid", out_valid, 0);
    check_eq("flush_done/busy", busy, 0);
    flush = 1'b0; out_ready = 1'b0;

    for (int i = 0; i < 60; i++) begin
      f = 3'($urandom); a = pick_operand(); b = pick_operand();
      do_op(0, f, a, b, 5'($urandom), ref_mdu(f, a, b), ref_lat(f, a, b, 1), 1,
            $sformatf("rnd%0d_f%0d_%h_%h", i, f, a, b));
    end
    for (int i = 0; i < 16; i++) begin
      f = 3'($urandom); a = pick_operand(); b = pick_operand();
      do_op(1, f, a, b, 5'($urandom), ref_mdu(f, a, b), ref_lat(f, a, b, 4), 1,
            $sformatf("rnd4_%0d_f%0d_%h_%h", i, f, a, b));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
